parking_lane_counter: RTL and testbench

- Multi-lane bidirectional vehicle counter for the parking-meter design.
- Each lane has two beam sensors, a (outer) and b (inner). A per-lane direction FSM classifies complete pass sequences as entries (a first) or exits (b first).
- A shared accumulator keeps saturating lot occupancy against a capacity limit, plus a wrapping lifetime entry total.

---
 rtl/parking_pkg.sv | 25 ++
 rtl/lane_dir_fsm.sv | 144 ++++++++++++++
 rtl/parking_lane_counter.sv | 96 +++++++++
 tb/tb_parking_lane_counter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared lane-state encodings and sensor-pair constants for the parking lane counter.
package parking_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        A_IN     = 4'd1,
        AB_IN    = 4'd2,
        B_IN     = 4'd3,
        B_EX     = 4'd4,
        AB_EX    = 4'd5,
        A_EX     = 4'd6,
        WAIT_CLR = 4'd7
    } lane_state_t;

    // Sensor pair is always packed as {a, b}
    localparam logic [1:0] AB_NONE = 2'b00;
    localparam logic [1:0] AB_A    = 2'b10;
    localparam logic [1:0] AB_B    = 2'b01;
    localparam logic [1:0] AB_BOTH = 2'b11;

    function automatic logic is_double(input logic [1:0] cur, input logic [1:0] prev);
        return (cur ^ prev) == AB_BOTH;
    endfunction

endpackage

// File: rtl/lane_dir_fsm.sv
// One lane: 2-flop sync, optional debounce (PARKING_DEBOUNCE_EN), direction FSM; pulses 2 cycles after sync input.
// No backpressure: entry/exit/err are single-cycle registered pulses.
module lane_dir_fsm
    import parking_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sens_a,
    input  logic sens_b,
    output logic entry,
    output logic exit,
    output logic err
);

    if (DEB_CYCLES < 2) begin : g_bad_deb
        $error("lane_dir_fsm: DEB_CYCLES must be >= 2");
    end

    logic [1:0]  meta;
    logic [1:0]  sync;
    logic [1:0]  ab;
    logic [1:0]  ab_prev;
    lane_state_t state_q;
    lane_state_t state_d;
    logic        entry_d;
    logic        exit_d;
    logic        err_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 2'b00;
            sync <= 2'b00;
        end else begin
            meta <= {sens_a, sens_b};
            sync <= meta;
        end
    end

`ifdef PARKING_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES + 1);

    for (genvar i = 0; i < 2; i++) begin : g_deb
        logic [CW-1:0] cnt;
        logic          filt;

        // Counts consecutive cycles the input disagrees with the filtered value
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt  <= '0;
                filt <= 1'b0;
            end else if (sync[i] == filt) begin
                cnt  <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                filt <= sync[i];
                cnt  <= '0;
            end else begin
                cnt  <= cnt + 1'b1;
            end
        end

        assign ab[i] = filt;
    end
`else
    assign ab = sync;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ab_prev <= AB_NONE;
            entry   <= 1'b0;
            exit    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            ab_prev <= ab;
            entry   <= entry_d;
            exit    <= exit_d;
            err     <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        entry_d = 1'b0;
        exit_d  = 1'b0;
        err_d   = 1'b0;
        // Both beams flipping in one sample means the pass order is unknowable
        if (state_q != WAIT_CLR && is_double(ab, ab_prev)) begin
            err_d   = 1'b1;
            state_d = (ab == AB_NONE) ? IDLE : WAIT_CLR;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ab == AB_A)      state_d = A_IN;
                    else if (ab == AB_B) state_d = B_EX;
                    else if (ab == AB_BOTH) begin
                        state_d = WAIT_CLR;
                        err_d   = 1'b1;
                    end
                end
                A_IN: begin
                    if (ab == AB_NONE)      state_d = IDLE;
                    else if (ab == AB_BOTH) state_d = AB_IN;
                end
                AB_IN: begin
                    if (ab == AB_A)      state_d = A_IN;
                    else if (ab == AB_B) state_d = B_IN;
                end
                B_IN: begin
                    if (ab == AB_NONE) begin
                        state_d = IDLE;
                        entry_d = 1'b1;
                    end else if (ab == AB_BOTH) begin
                        state_d = AB_IN;
                    end
                end
                B_EX: begin
                    if (ab == AB_NONE)      state_d = IDLE;
                    else if (ab == AB_BOTH) state_d = AB_EX;
                end
                AB_EX: begin
                    if (ab == AB_B)      state_d = B_EX;
                    else if (ab == AB_A) state_d = A_EX;
                end
                A_EX: begin
                    if (ab == AB_NONE) begin
                        state_d = IDLE;
                        exit_d  = 1'b1;
                    end else if (ab == AB_BOTH) begin
                        state_d = AB_EX;
                    end
                end
                WAIT_CLR: begin
                    if (ab == AB_NONE) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/parking_lane_counter.sv
// Multi-lane entry/exit counter with saturating occupancy; occupancy updates one cycle after lane pulses.
// No backpressure; debounce option via PARKING_DEBOUNCE_EN adds DEB_CYCLES of latency per lane.
module parking_lane_counter
    import parking_pkg::*;
#(
    parameter int N_LANES    = 2,
    parameter int CNT_W      = 8,
    parameter int CAPACITY   = 200,
    parameter int DEB_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_LANES-1:0] sens_a,
    input  logic [N_LANES-1:0] sens_b,
    input  logic               clr,
    output logic [N_LANES-1:0] entry_pulse,
    output logic [N_LANES-1:0] exit_pulse,
    output logic [N_LANES-1:0] seq_err,
    output logic [CNT_W-1:0]   occupancy,
    output logic [CNT_W-1:0]   total_in,
    output logic               full,
    output logic               empty,
    output logic               ovf_pulse,
    output logic               unf_pulse
);

    if (N_LANES < 1 || N_LANES > 8) begin : g_bad_lanes
        $error("parking_lane_counter: N_LANES must be 1..8");
    end
    if (CAPACITY < 1 || CAPACITY >= 2**CNT_W) begin : g_bad_cap
        $error("parking_lane_counter: CAPACITY must fit below 2**CNT_W");
    end

    localparam int SW = CNT_W + 2;
    localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        lane_dir_fsm #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .sens_a(sens_a[i]),
            .sens_b(sens_b[i]),
            .entry (entry_pulse[i]),
            .exit  (exit_pulse[i]),
            .err   (seq_err[i])
        );
    end

    logic [SW-1:0]        n_in;
    logic [SW-1:0]        n_out;
    logic signed [SW-1:0] sum;

    always_comb begin
        n_in  = '0;
        n_out = '0;
        for (int i = 0; i < N_LANES; i++) begin
            n_in  = n_in + SW'(entry_pulse[i]);
            n_out = n_out + SW'(exit_pulse[i]);
        end
        // Two guard bits keep both the overshoot and the undershoot representable
        sum = $signed({2'b00, occupancy}) + $signed(n_in) - $signed(n_out);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occupancy <= '0;
            total_in  <= '0;
            ovf_pulse <= 1'b0;
            unf_pulse <= 1'b0;
        end else if (clr) begin
            occupancy <= '0;
            total_in  <= '0;
            ovf_pulse <= 1'b0;
            unf_pulse <= 1'b0;
        end else begin
            ovf_pulse <= 1'b0;
            unf_pulse <= 1'b0;
            if (sum > CAP_S) begin
                occupancy <= CNT_W'(CAPACITY);
                ovf_pulse <= 1'b1;
            end else if (sum < 0) begin
                occupancy <= '0;
                unf_pulse <= 1'b1;
            end else begin
                occupancy <= sum[CNT_W-1:0];
            end
            total_in <= total_in + n_in[CNT_W-1:0];
        end
    end

    assign full  = (occupancy == CNT_W'(CAPACITY));
    assign empty = (occupancy == '0);

endmodule

// File: tb/tb_parking_lane_counter.sv
// Directed and randomized bench for parking_lane_counter against a pass-order reference model.
module tb_parking_lane_counter;

    localparam int N   = 2;
    localparam int CW  = 8;
    localparam int CAP = 200;
    localparam int DEB = 4;
`ifdef PARKING_DEBOUNCE_EN
    localparam int H = 4 + DEB;
`else
    localparam int H = 4;
`endif

    localparam logic [7:0] ENT = 8'b10_11_01_00;
    localparam logic [7:0] EXT = 8'b01_11_10_00;
    localparam logic [7:0] IDL = 8'b00_00_00_00;
    localparam logic [7:0] BCK = 8'b10_11_10_00;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  sens_a;
    logic [N-1:0]  sens_b;
    logic          clr;
    logic [N-1:0]  entry_pulse;
    logic [N-1:0]  exit_pulse;
    logic [N-1:0]  seq_err;
    logic [CW-1:0] occupancy;
    logic [CW-1:0] total_in;
    logic          full;
    logic          empty;
    logic          ovf_pulse;
    logic          unf_pulse;

    parking_lane_counter #(
        .N_LANES(N), .CNT_W(CW), .CAPACITY(CAP), .DEB_CYCLES(DEB)
    ) dut (
        .clk(clk), .reset(reset), .sens_a(sens_a), .sens_b(sens_b), .clr(clr),
        .entry_pulse(entry_pulse), .exit_pulse(exit_pulse), .seq_err(seq_err),
        .occupancy(occupancy), .total_in(total_in), .full(full), .empty(empty),
        .ovf_pulse(ovf_pulse), .unf_pulse(unf_pulse)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: per lane, which beam broke first (0 none, 1 a, 2 b, 3 wait for clear)
    int         m_occ;
    int         m_tot;
    int         origin [N];
    logic [1:0] prev [N];
    logic [1:0] cur [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_occ = 0;
        m_tot = 0;
        for (int i = 0; i < N; i++) begin
            origin[i] = 0;
            prev[i]   = 2'b00;
        end
    endtask

    task automatic model_lane(input int i, input logic [1:0] v, output int e, output int x, output int r);
        e = 0; x = 0; r = 0;
        if (v != prev[i]) begin
            if (origin[i] == 3) begin
                if (v == 2'b00) origin[i] = 0;
            end else if ((v ^ prev[i]) == 2'b11) begin
                r = 1;
                origin[i] = (v == 2'b00) ? 0 : 3;
            end else if (v == 2'b00) begin
                if (origin[i] == 1 && prev[i] == 2'b01) e = 1;
                if (origin[i] == 2 && prev[i] == 2'b10) x = 1;
                origin[i] = 0;
            end else if (prev[i] == 2'b00) begin
                origin[i] = (v == 2'b10) ? 1 : 2;
            end
            prev[i] = v;
        end
    endtask

    task automatic step(input logic [1:0] v0, input logic [1:0] v1);
        logic [1:0] vv [N];
        int me [N]; int mx [N]; int mr [N];
        int oe [N]; int ox [N]; int orr [N];
        int sum, xo, xu, oo, ou, ne, nx;
        vv[0] = v0; vv[1] = v1;
        sens_a = {v1[1], v0[1]};
        sens_b = {v1[0], v0[0]};
        ne = 0; nx = 0;
        for (int i = 0; i < N; i++) begin
            model_lane(i, vv[i], me[i], mx[i], mr[i]);
            ne += me[i]; nx += mx[i];
            oe[i] = 0; ox[i] = 0; orr[i] = 0;
        end
        sum = m_occ + ne - nx; xo = 0; xu = 0;
        if (sum > CAP)    begin m_occ = CAP; xo = 1; end
        else if (sum < 0) begin m_occ = 0;   xu = 1; end
        else              m_occ = sum;
        m_tot = (m_tot + ne) % 256;
        oo = 0; ou = 0;
        for (int c = 0; c < H; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                oe[i]  += int'(entry_pulse[i]);
                ox[i]  += int'(exit_pulse[i]);
                orr[i] += int'(seq_err[i]);
            end
            oo += int'(ovf_pulse);
            ou += int'(unf_pulse);
        end
        for (int i = 0; i < N; i++) begin
            chk($sformatf("entry_pulse[%0d]", i), oe[i], me[i]);
            chk($sformatf("exit_pulse[%0d]", i), ox[i], mx[i]);
            chk($sformatf("seq_err[%0d]", i), orr[i], mr[i]);
        end
        chk("ovf_pulse", oo, xo);
        chk("unf_pulse", ou, xu);
        chk("occupancy", occupancy, m_occ);
        chk("total_in", total_in, m_tot);
        chk("full", full, m_occ == CAP);
        chk("empty", empty, m_occ == 0);
    endtask

    task automatic seq4(input logic [7:0] s0, input logic [7:0] s1);
        for (int k = 0; k < 4; k++) step(s0[7-2*k -: 2], s1[7-2*k -: 2]);
    endtask

    initial begin
        reset  = 1'b1;
        sens_a = '0;
        sens_b = '0;
        clr    = 1'b0;
        model_reset();
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_total_in", total_in, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_pulses", {entry_pulse, exit_pulse, seq_err, ovf_pulse, unf_pulse}, 0);
        reset = 1'b1;

        // Single entry, two double entries, one exit
        seq4(ENT, IDL);
        chk("entry_occ", occupancy, 1);
        seq4(ENT, ENT);
        seq4(ENT, ENT);
        seq4(IDL, EXT);
        chk("exit_occ", occupancy, 4);
        chk("exit_total", total_in, 5);

        // Back-out and a double-change error: no counts
        seq4(BCK, IDL);
        step(2'b11, 2'b00);
        step(2'b00, 2'b00);
        chk("abort_occ", occupancy, 4);

        // Fill to 199, then two simultaneous entries overflow
        seq4(ENT, IDL);
        repeat (97) seq4(ENT, ENT);
        chk("fill_occ", occupancy, 199);
        seq4(ENT, ENT);
        chk("sat_occ", occupancy, CAP);
        chk("sat_full", full, 1);
        chk("sat_total", total_in, 202);

        // Drain to 0, then an exit underflows
        repeat (100) seq4(EXT, EXT);
        seq4(IDL, EXT);
        chk("unf_occ", occupancy, 0);
        chk("unf_empty", empty, 1);

        // Same-cycle entry and exit cancel
        seq4(ENT, ENT);
        seq4(ENT, IDL);
        seq4(ENT, EXT);
        chk("cancel_occ", occupancy, 3);
        chk("cancel_total", total_in, 206);

        // total_in wraps past 255
        repeat (30) seq4(ENT, ENT);
        chk("total_wrap", total_in, 10);

        // Randomized walks, biased toward single-beam changes
        for (int i = 0; i < N; i++) cur[i] = 2'b00;
        for (int s = 0; s < 300; s++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 9) < 7) cur[i] = cur[i] ^ (2'b01 << $urandom_range(0, 1));
                else                          cur[i] = 2'($urandom_range(0, 3));
            end
            step(cur[0], cur[1]);
        end
        step(2'b00, 2'b00);
        step(2'b00, 2'b00);

        // clr lands in the same cycle as an entry pulse
        step(2'b10, 2'b00);
        step(2'b11, 2'b00);
        step(2'b01, 2'b00);
        sens_a[0] = 1'b0;
        sens_b[0] = 1'b0;
        begin
            int e0, x0, r0;
            model_lane(0, 2'b00, e0, x0, r0);
        end
        repeat (H - 2) @(negedge clk);
        @(negedge clk);
        chk("clr_entry_seen", entry_pulse[0], 1);
        clr = 1'b1;
        @(negedge clk);
        clr   = 1'b0;
        m_occ = 0;
        m_tot = 0;
        chk("clr_occ", occupancy, 0);
        chk("clr_total", total_in, 0);
        step(2'b00, 2'b00);

        // Reset with lane0 in the middle of a pass
        seq4(ENT, ENT);
        step(2'b10, 2'b00);
        step(2'b11, 2'b00);
        reset = 1'b0;
        #1;
        chk("midrst_occ", occupancy, 0);
        chk("midrst_total", total_in, 0);
        chk("midrst_empty", empty, 1);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        step(2'b11, 2'b00);
        step(2'b01, 2'b00);
        step(2'b00, 2'b00);
        chk("midrst_no_count", total_in, 0);

`ifdef PARKING_DEBOUNCE_EN
        // Glitches shorter than the debounce window must not reach the FSM
        sens_a[0] = 1'b1;
        repeat (2) @(negedge clk);
        sens_a[0] = 1'b0;
        step(2'b00, 2'b00);
        sens_a[0] = 1'b1;
        sens_b[0] = 1'b1;
        repeat (2) @(negedge clk);
        sens_a[0] = 1'b0;
        sens_b[0] = 1'b0;
        step(2'b00, 2'b00);
        seq4(ENT, IDL);
        chk("deb_entry_occ", occupancy, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
